// File: rtl/seq_control_unit_if.sv
// seq_control_unit_if: handshake and control-bus bundle between the
// sequencer (slave side) and whoever drives the instruction register and
// consumes the datapath controls (master side).
interface seq_control_unit_if #(
  parameter int IR_W = 8,
  parameter int NREG = 13
) ();

  logic            start;
  logic [IR_W-1:0] ir;
  logic            z;

  logic            busy;
  logic            end_op;
  logic            err;
  logic [1:0]      inc;
  logic [3:0]      alu_mode;
  logic [3:0]      bus_ld;
  logic [NREG-1:0] write_en;
  logic [2:0]      clr;
  logic            dm_wr;
  logic            im_wr;

  modport master (
    output start, ir, z,
    input  busy, end_op, err, inc, alu_mode, bus_ld, write_en, clr, dm_wr, im_wr
  );

  modport slave (
    input  start, ir, z,
    output busy, end_op, err, inc, alu_mode, bus_ld, write_en, clr, dm_wr, im_wr
  );

endinterface

// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle fetch/decode/execute sequencer for the
// single-core matrix multiplier. Every output is a Moore output held in a
// register that is loaded with the decode of the state being entered, so
// the pins never glitch and reset clears them asynchronously.
//
// Optional feature: define CU_ILLEGAL_TRAP_EN to send illegal opcodes to a
// TRAP state (err=1, left only by reset). Without it, illegal opcodes run
// as NOP and err stays 0.
module seq_control_unit #(
  parameter int IR_W     = 8,
  parameter int NREG     = 13,
  parameter int WAIT_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_control_unit_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_EXEC1, S_EXEC2, S_EXEC3, S_HALT, S_TRAP
  } state_e;

  typedef enum logic [4:0] {
    OP_NOP  = 5'h00,
    OP_LDAC = 5'h01,
    OP_STAC = 5'h02,
    OP_ADD  = 5'h03,
    OP_MUL  = 5'h04,
    OP_CLAC = 5'h05,
    OP_JPNZ = 5'h06,
    OP_END  = 5'h07,
    OP_IMWR = 5'h08
  } op_e;

  typedef struct packed {
    logic            busy;
    logic            end_op;
    logic            err;
    logic [1:0]      inc;
    logic [3:0]      alu_mode;
    logic [3:0]      bus_ld;
    logic [NREG-1:0] write_en;
    logic [2:0]      clr;
    logic            dm_wr;
    logic            im_wr;
  } out_t;

  // Last count value of the fetch wait and of the LDAC read wait (min 1).
  localparam logic [3:0] FETCH_LAST = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  localparam int         LD_WAIT    = (WAIT_CYC > 0) ? WAIT_CYC : 1;
  localparam logic [3:0] LD_LAST    = 4'(LD_WAIT - 1);

  state_e     r_state;
  logic [4:0] r_opcode;
  logic [3:0] r_cnt;
  logic       r_armed;
  out_t       r_out;

  // Only the low five instruction bits carry the opcode.
  logic w_unused_ir;
  assign w_unused_ir = ^bus.ir[IR_W-1:5];

  // Output decode for the state about to be entered; zf only matters for JPNZ.
  function automatic out_t moore(state_e s, logic [4:0] op, logic zf);
    out_t o;
    o      = '0;
    o.busy = (s != S_IDLE) && (s != S_HALT) && (s != S_TRAP);
    case (s)
      S_FETCH1: begin
        o.bus_ld      = 4'd1;
        o.write_en[0] = 1'b1;
      end
      S_FETCH3: begin
        o.write_en[2] = 1'b1;
        o.inc         = 2'b01;
      end
      S_EXEC1: begin
        case (op)
          OP_STAC: begin
            o.bus_ld      = 4'd3;
            o.write_en[3] = 1'b1;
          end
          OP_ADD: begin
            o.alu_mode    = 4'd1;
            o.write_en[4] = 1'b1;
          end
          OP_MUL: begin
            o.alu_mode    = 4'd3;
            o.write_en[4] = 1'b1;
          end
          OP_CLAC: o.clr = 3'b001;
          OP_JPNZ: begin
            if (zf) begin
              o.inc = 2'b01;
            end else begin
              o.bus_ld      = 4'd2;
              o.write_en[1] = 1'b1;
            end
          end
          OP_IMWR: o.im_wr = 1'b1;
          default: ;
        endcase
      end
      S_EXEC2: begin
        if (op == OP_LDAC) begin
          o.write_en[3] = 1'b1;
        end else if (op == OP_STAC) begin
          o.dm_wr = 1'b1;
        end
      end
      S_EXEC3: begin
        o.bus_ld      = 4'd2;
        o.write_en[4] = 1'b1;
      end
      S_HALT: o.end_op = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
      S_TRAP: o.err = 1'b1;
`endif
      default: ;
    endcase
    return o;
  endfunction

  // Sequencer: state transitions, wait counting and registered outputs.
  // NOTE: state and output registers use non-blocking assignments so every
  // register samples pre-edge values; blocking here would create order-
  // dependent simulation and mismatch synthesis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_opcode <= '0;
      r_cnt    <= '0;
      r_armed  <= 1'b0;
      r_out    <= '0;
    end else begin
      // A start seen on the first edge after reset release is ignored.
      r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.start && r_armed) begin
            r_state <= S_FETCH1;
            r_out   <= moore(S_FETCH1, r_opcode, 1'b0);
          end
        end
        S_FETCH1: begin
          if (WAIT_CYC == 0) begin
            r_state <= S_FETCH3;
            r_out   <= moore(S_FETCH3, r_opcode, 1'b0);
          end else begin
            r_state <= S_FETCH2;
            r_cnt   <= FETCH_LAST;
            r_out   <= moore(S_FETCH2, r_opcode, 1'b0);
          end
        end
        S_FETCH2: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_FETCH3;
            r_out   <= moore(S_FETCH3, r_opcode, 1'b0);
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_FETCH3: begin
          r_state <= S_DECODE;
          r_out   <= moore(S_DECODE, r_opcode, 1'b0);
        end
        S_DECODE: begin
          r_opcode <= bus.ir[4:0];
`ifdef CU_ILLEGAL_TRAP_EN
          if (bus.ir[4:0] > OP_IMWR) begin
            r_state <= S_TRAP;
            r_out   <= moore(S_TRAP, bus.ir[4:0], bus.z);
          end else
`endif
          begin
            r_state <= S_EXEC1;
            r_cnt   <= LD_LAST;
            r_out   <= moore(S_EXEC1, bus.ir[4:0], bus.z);
          end
        end
        S_EXEC1: begin
          case (r_opcode)
            OP_LDAC: begin
              if (r_cnt == 4'd0) begin
                r_state <= S_EXEC2;
                r_out   <= moore(S_EXEC2, r_opcode, 1'b0);
              end else begin
                r_cnt <= r_cnt - 4'd1;
              end
            end
            OP_STAC: begin
              r_state <= S_EXEC2;
              r_out   <= moore(S_EXEC2, r_opcode, 1'b0);
            end
            OP_END: begin
              r_state <= S_HALT;
              r_out   <= moore(S_HALT, r_opcode, 1'b0);
            end
            default: begin
              r_state <= S_FETCH1;
              r_out   <= moore(S_FETCH1, r_opcode, 1'b0);
            end
          endcase
        end
        S_EXEC2: begin
          if (r_opcode == OP_LDAC) begin
            r_state <= S_EXEC3;
            r_out   <= moore(S_EXEC3, r_opcode, 1'b0);
          end else begin
            r_state <= S_FETCH1;
            r_out   <= moore(S_FETCH1, r_opcode, 1'b0);
          end
        end
        S_EXEC3: begin
          r_state <= S_FETCH1;
          r_out   <= moore(S_FETCH1, r_opcode, 1'b0);
        end
        S_HALT: begin
          if (bus.start) begin
            r_state <= S_FETCH1;
            r_out   <= moore(S_FETCH1, r_opcode, 1'b0);
          end
        end
        S_TRAP: ;
        default: begin
          r_state <= S_IDLE;
          r_out   <= '0;
        end
      endcase
    end
  end

  assign bus.busy     = r_out.busy;
  assign bus.end_op   = r_out.end_op;
  assign bus.err      = r_out.err;
  assign bus.inc      = r_out.inc;
  assign bus.alu_mode = r_out.alu_mode;
  assign bus.bus_ld   = r_out.bus_ld;
  assign bus.write_en = r_out.write_en;
  assign bus.clr      = r_out.clr;
  assign bus.dm_wr    = r_out.dm_wr;
  assign bus.im_wr    = r_out.im_wr;

endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: drives directed and random instruction streams into
// seq_control_unit and compares every cycle against a per-instruction
// cycle-list model built from the instruction timing rules.
module tb_seq_control_unit;

  localparam int IR_W = 8;
  localparam int NREG = 13;
  localparam int W    = 1;
`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int ST_RUN   = 0;
  localparam int ST_HALT  = 1;
  localparam int ST_TRAP  = 2;
  localparam int ST_ABORT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seq_control_unit_if #(.IR_W(IR_W), .NREG(NREG)) u_if ();

  seq_control_unit #(.IR_W(IR_W), .NREG(NREG), .WAIT_CYC(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  typedef struct packed {
    logic            busy;
    logic            end_op;
    logic            err;
    logic [1:0]      inc;
    logic [3:0]      alu;
    logic [3:0]      bus_ld;
    logic [NREG-1:0] we;
    logic [2:0]      clr;
    logic            dm;
    logic            im;
  } vec_t;

  int    checks   = 0;
  int    failures = 0;
  vec_t  exp_o    = '0;
  bit    exp_v    = 1'b0;
  string exp_tag  = "";
  vec_t  mq[$];

  function automatic vec_t got();
    vec_t g;
    g.busy   = u_if.busy;
    g.end_op = u_if.end_op;
    g.err    = u_if.err;
    g.inc    = u_if.inc;
    g.alu    = u_if.alu_mode;
    g.bus_ld = u_if.bus_ld;
    g.we     = u_if.write_en;
    g.clr    = u_if.clr;
    g.dm     = u_if.dm_wr;
    g.im     = u_if.im_wr;
    return g;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  // Every cycle with a model expectation: full output vector plus invariants.
  always @(negedge clk) begin
    if (exp_v) begin
      check({"cycle ", exp_tag}, 64'(got()), 64'(exp_o));
      check("we_onehot0", 64'($onehot0(u_if.write_en)), 64'd1);
      check("wr_exclusive", 64'(u_if.dm_wr & u_if.im_wr), 64'd0);
    end
  end

  function automatic bit illegal(input logic [4:0] op);
    return op > 5'h08;
  endfunction

  function automatic vec_t halt_v();
    vec_t t;
    t        = '0;
    t.end_op = 1'b1;
    return t;
  endfunction

  function automatic vec_t trap_v();
    vec_t t;
    t     = '0;
    t.err = 1'b1;
    return t;
  endfunction

  // Cycle list of one instruction from FETCH1 up to its last busy cycle.
  function automatic void model_instr(input logic [4:0] op, input logic zv);
    vec_t b;
    vec_t t;
    b      = '0;
    b.busy = 1'b1;
    t = b; t.bus_ld = 4'd1; t.we[0] = 1'b1; mq.push_back(t);
    for (int k = 0; k < W; k++) mq.push_back(b);
    t = b; t.we[2] = 1'b1; t.inc = 2'b01; mq.push_back(t);
    mq.push_back(b);
    if (illegal(op) && TRAP_EN) return;
    case (op)
      5'h01: begin
        for (int k = 0; k < ((W == 0) ? 1 : W); k++) mq.push_back(b);
        t = b; t.we[3] = 1'b1; mq.push_back(t);
        t = b; t.bus_ld = 4'd2; t.we[4] = 1'b1; mq.push_back(t);
      end
      5'h02: begin
        t = b; t.bus_ld = 4'd3; t.we[3] = 1'b1; mq.push_back(t);
        t = b; t.dm = 1'b1; mq.push_back(t);
      end
      5'h03: begin t = b; t.alu = 4'd1; t.we[4] = 1'b1; mq.push_back(t); end
      5'h04: begin t = b; t.alu = 4'd3; t.we[4] = 1'b1; mq.push_back(t); end
      5'h05: begin t = b; t.clr = 3'b001; mq.push_back(t); end
      5'h06: begin
        t = b;
        if (zv) t.inc = 2'b01;
        else begin t.bus_ld = 4'd2; t.we[1] = 1'b1; end
        mq.push_back(t);
      end
      5'h08: begin t = b; t.im = 1'b1; mq.push_back(t); end
      default: mq.push_back(b);
    endcase
  endfunction

  task automatic step(input vec_t e, input string tag);
    @(posedge clk);
    #1;
    exp_o   = e;
    exp_tag = tag;
    exp_v   = 1'b1;
  endtask

  // Hand-computed literal values for selected cycles of directed instructions.
  task automatic pin_check(input logic [4:0] op, input logic zv, input int i);
    @(negedge clk);
    #1;
    if (op == 5'h00 && i == 0) begin
      check("f1_write_en", 64'(u_if.write_en), 64'h0001);
      check("f1_bus_ld", 64'(u_if.bus_ld), 64'd1);
      check("f1_busy", 64'(u_if.busy), 64'd1);
      check("f1_end_op", 64'(u_if.end_op), 64'd0);
    end
    if (op == 5'h00 && i == 2) begin
      check("f3_write_en", 64'(u_if.write_en), 64'h0004);
      check("f3_inc", 64'(u_if.inc), 64'd1);
    end
    if (op == 5'h00 && i == 4) begin
      check("nop_exec_write_en", 64'(u_if.write_en), 64'h0000);
      check("nop_exec_bus_ld", 64'(u_if.bus_ld), 64'd0);
    end
    if (op == 5'h01 && i == 5) check("ldac_e2_write_en", 64'(u_if.write_en), 64'h0008);
    if (op == 5'h01 && i == 6) begin
      check("ldac_e3_bus_ld", 64'(u_if.bus_ld), 64'd2);
      check("ldac_e3_write_en", 64'(u_if.write_en), 64'h0010);
    end
    if (op == 5'h06 && i == 4) begin
      if (zv) begin
        check("jpnz_z1_inc", 64'(u_if.inc), 64'd1);
        check("jpnz_z1_write_en", 64'(u_if.write_en), 64'h0000);
      end else begin
        check("jpnz_z0_bus_ld", 64'(u_if.bus_ld), 64'd2);
        check("jpnz_z0_write_en", 64'(u_if.write_en), 64'h0002);
      end
    end
    if (illegal(op) && i == 4) begin
      check("illegal_nop_err", 64'(u_if.err), 64'd0);
      check("illegal_nop_write_en", 64'(u_if.write_en), 64'h0000);
    end
  endtask

  task automatic run_instr(input logic [4:0] op, input logic zv, input bit pin,
                           input int abort_at, output int st);
    vec_t e;
    int   i;
    model_instr(op, zv);
    i  = 0;
    st = ST_RUN;
    while (mq.size() > 0) begin
      e = mq.pop_front();
      step(e, $sformatf("op%0h c%0d", op, i));
      if (i == 0) begin
        u_if.ir      = IR_W'($urandom);
        u_if.ir[4:0] = op;
        u_if.z       = zv;
      end
      u_if.start = 1'($urandom_range(0, 1));
      if (pin) pin_check(op, zv, i);
      if (i == abort_at) begin
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        exp_o   = '0;
        exp_tag = "abort";
        #1;
        check("abort_async_zero", 64'(got()), 64'd0);
        mq.delete();
        st = ST_ABORT;
      end
      i++;
    end
    if (st != ST_ABORT) begin
      if (op == 5'h07) st = ST_HALT;
      else if (illegal(op) && TRAP_EN) st = ST_TRAP;
    end
  endtask

  task automatic do_reset(input bit start_at_release);
    rst_n      = 1'b0;
    exp_o      = '0;
    u_if.start = 1'b0;
    step('0, "rst");
    step('0, "rst");
    rst_n      = 1'b1;
    u_if.start = start_at_release;
    step('0, "release");
    u_if.start = 1'b0;
    step('0, "idle");
  endtask

  task automatic launch(input vec_t cur);
    step(cur, "launch");
    u_if.start = 1'b1;
  endtask

  task automatic handle_status(input int st);
    case (st)
      ST_HALT: begin
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
          step(halt_v(), "halt");
          u_if.start = 1'b0;
        end
        launch(halt_v());
      end
      ST_TRAP: begin
        for (int k = 0; k < int'($urandom_range(2, 4)); k++) begin
          step(trap_v(), "trap");
          u_if.start = 1'($urandom_range(0, 1));
        end
        do_reset(1'($urandom_range(0, 1)));
        launch('0);
      end
      ST_ABORT: begin
        do_reset(1'b0);
        launch('0);
      end
      default: ;
    endcase
  endtask

  initial begin
    int         st;
    logic [4:0] op;
    int         abort_at;
    u_if.start = 1'b0;
    u_if.ir    = '0;
    u_if.z     = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_outputs", 64'(got()), 64'd0);

    // Start held high across reset release must not launch.
    do_reset(1'b1);
    check("release_start_busy", 64'(u_if.busy), 64'd0);
    launch('0);

    // Directed program.
    run_instr(5'h00, 1'b0, 1'b1, -1, st);
    run_instr(5'h01, 1'b0, 1'b1, -1, st);
    run_instr(5'h00, 1'b0, 1'b1, -1, st);
    run_instr(5'h06, 1'b0, 1'b1, -1, st);
    run_instr(5'h06, 1'b1, 1'b1, -1, st);
    run_instr(5'h03, 1'b0, 1'b0, -1, st);
    run_instr(5'h04, 1'b1, 1'b0, -1, st);
    run_instr(5'h05, 1'b0, 1'b0, -1, st);
    run_instr(5'h02, 1'b0, 1'b0, -1, st);
    run_instr(5'h08, 1'b0, 1'b0, -1, st);
    run_instr(5'h07, 1'b0, 1'b0, -1, st);
    check("end_status_halt", 64'(st), 64'(ST_HALT));
    for (int k = 0; k < 10; k++) begin
      step(halt_v(), "halt_hold");
      u_if.start = 1'b0;
    end
    @(negedge clk);
    #1;
    check("halt_end_op", 64'(u_if.end_op), 64'd1);
    check("halt_busy", 64'(u_if.busy), 64'd0);
    launch(halt_v());
    run_instr(5'h00, 1'b0, 1'b1, -1, st);

    // Illegal opcode.
    run_instr(5'h1F, 1'b0, 1'b1, -1, st);
`ifdef CU_ILLEGAL_TRAP_EN
    step(trap_v(), "trap");
    u_if.start = 1'b1;
    step(trap_v(), "trap_start");
    u_if.start = 1'b0;
    step(trap_v(), "trap");
    @(negedge clk);
    #1;
    check("trap_err", 64'(u_if.err), 64'd1);
    check("trap_busy", 64'(u_if.busy), 64'd0);
    do_reset(1'b0);
    check("trap_cleared_err", 64'(u_if.err), 64'd0);
    launch('0);
`else
    check("illegal_status_run", 64'(st), 64'(ST_RUN));
`endif

    // Reset during STAC EXEC1.
    run_instr(5'h02, 1'b0, 1'b0, 4, st);
    handle_status(st);
    run_instr(5'h00, 1'b0, 1'b1, -1, st);

    // Random instruction stream.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(9, 31));
      else op = 5'($urandom_range(0, 8));
      abort_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, 1'($urandom_range(0, 1)), 1'b0, abort_at, st);
      handle_status(st);
    end

    @(negedge clk);
    exp_v = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
